// File: rtl/marsohod2_wb_gpio.sv
// Wishbone classic GPIO slave for the Marsohod2 board: LEDs, 8-bit IO header with direction
// control, and a debounced KEY1 with sticky press flag driving irq_o.
module marsohod2_wb_gpio #(
    parameter int          DEBOUNCE_CYCLES = 240000,
    parameter int          CNT_W           = 18,
    parameter logic [3:0]  LED_RESET       = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [3:0]  led_o,
    output logic [7:0]  io_o,
    output logic [7:0]  io_oe,
    input  logic [7:0]  io_i,
    input  logic        key1_i,
    output logic        irq_o
);

    localparam logic [1:0] REG_LED    = 2'd0;
    localparam logic [1:0] REG_IO_OUT = 2'd1;
    localparam logic [1:0] REG_IO_DIR = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic [3:0]        r_led;
    logic [7:0]        r_io_out;
    logic [7:0]        r_io_dir;
    logic [7:0]        r_io_s1;
    logic [7:0]        r_io_s2;
    logic              r_key_s1;
    logic              r_key_s2;
    logic              r_key_lvl;
    logic              r_key_evt;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_req;
    logic              w_wr;
    logic              w_sel0_wr;
    logic              w_ks_ne;
    logic              w_deb_done;
    logic              w_press;
    logic              w_w1c;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr       = w_req & wb_we_i;
    assign w_sel0_wr  = w_wr & wb_sel_i[0];
    assign w_ks_ne    = r_key_s2 != r_key_lvl;
    assign w_deb_done = w_ks_ne && (r_cnt == CNT_LAST);
    assign w_press    = w_deb_done & ~r_key_s2;
    assign w_w1c      = w_wr && (wb_adr_i[3:2] == REG_STATUS) && wb_sel_i[1] && wb_dat_i[9];
    assign w_unused   = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:10]};

    always_comb begin
        w_rdata = 32'd0;
        case (wb_adr_i[3:2])
            REG_LED:    w_rdata = {28'd0, r_led};
            REG_IO_OUT: w_rdata = {24'd0, r_io_out};
            REG_IO_DIR: w_rdata = {24'd0, r_io_dir};
            REG_STATUS: w_rdata = {22'd0, r_key_evt, r_key_lvl, r_io_s2};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_led    <= LED_RESET;
            r_io_out <= 8'd0;
            r_io_dir <= 8'd0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rdata : 32'd0;
            if (w_sel0_wr && wb_adr_i[3:2] == REG_LED)    r_led    <= wb_dat_i[3:0];
            if (w_sel0_wr && wb_adr_i[3:2] == REG_IO_OUT) r_io_out <= wb_dat_i[7:0];
            if (w_sel0_wr && wb_adr_i[3:2] == REG_IO_DIR) r_io_dir <= wb_dat_i[7:0];
        end
    end

    // Synchronizers reset to 1 so a released key (active-low) is seen right after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_io_s1  <= 8'hFF;
            r_io_s2  <= 8'hFF;
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
        end else begin
            r_io_s1  <= io_i;
            r_io_s2  <= r_io_s1;
            r_key_s1 <= key1_i;
            r_key_s2 <= r_key_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_key_lvl <= 1'b1;
            r_cnt     <= '0;
        end else if (!w_ks_ne) begin
            r_cnt <= '0;
        end else if (w_deb_done) begin
            r_key_lvl <= r_key_s2;
            r_cnt     <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A press on the same edge as a W1C keeps the flag set.
    always_ff @(posedge clock) begin
        if (!reset_n)      r_key_evt <= 1'b0;
        else if (w_press)  r_key_evt <= 1'b1;
        else if (w_w1c)    r_key_evt <= 1'b0;
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign led_o    = r_led;
    assign io_o     = r_io_out;
    assign io_oe    = r_io_dir;
    assign irq_o    = r_key_evt;

endmodule

// File: tb/tb_marsohod2_wb_gpio.sv
// Self-checking bench for marsohod2_wb_gpio with a behavioural reference model.
module tb_marsohod2_wb_gpio;

    localparam int         D  = 8;
    localparam logic [3:0] LR = 4'h6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_stb_i, wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  led_o;
    logic [7:0]  io_o, io_oe, io_i;
    logic        key1_i, irq_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    marsohod2_wb_gpio #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .LED_RESET(LR)) dut (
        .clock(clk), .reset_n(reset_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .led_o(led_o), .io_o(io_o), .io_oe(io_oe),
        .io_i(io_i), .key1_i(key1_i), .irq_o(irq_o)
    );

    // Reference model: registers, delayed pad views and a window-based debounce.
    logic [3:0]  m_led = LR;
    logic [7:0]  m_out = 0, m_dir = 0;
    logic        m_lvl = 1, m_evt = 0;
    logic [7:0]  io_h1 = 8'hFF, io_h2 = 8'hFF;
    logic        k_h1 = 1, k_h2 = 1;
    logic        win[$];
    logic [31:0] m_stat_pre = 0;
    bit          m_w1c = 0;
    int          m_presses = 0;
    bit          m_press, m_all;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_led = LR; m_out = 0; m_dir = 0; m_lvl = 1; m_evt = 0;
            io_h1 = 8'hFF; io_h2 = 8'hFF; k_h1 = 1; k_h2 = 1;
            win.delete(); m_w1c = 0; m_stat_pre = 0;
        end else begin
            m_stat_pre = {22'd0, m_evt, m_lvl, io_h2};
            win.push_back(k_h2);
            if (win.size() > D) void'(win.pop_front());
            m_press = 0;
            if (win.size() == D) begin
                m_all = 1;
                foreach (win[i]) if (win[i] == m_lvl) m_all = 0;
                if (m_all) begin
                    m_lvl = ~m_lvl;
                    if (!m_lvl) m_press = 1;
                end
            end
            if (m_press) begin m_evt = 1; m_presses++; end
            else if (m_w1c) m_evt = 0;
            m_w1c = 0;
            io_h2 = io_h1; io_h1 = io_i;
            k_h2 = k_h1;   k_h1 = key1_i;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wb_access(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, output logic [31:0] rd, output logic [31:0] exp_rd,
                             output bit hs_ok);
        logic a0, a1, a2;
        logic [31:0] d2;
        a0 = wb_ack_o;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1; wb_stb_i = 1;
        if (we && adr[3:2] == 2'd3 && sel[1] && dat[9]) m_w1c = 1;
        step();
        a1 = wb_ack_o; rd = wb_dat_o;
        exp_rd = 0;
        if (!we) begin
            case (adr[3:2])
                2'd0: exp_rd = {28'd0, m_led};
                2'd1: exp_rd = {24'd0, m_out};
                2'd2: exp_rd = {24'd0, m_dir};
                default: exp_rd = m_stat_pre;
            endcase
        end else if (sel[0]) begin
            case (adr[3:2])
                2'd0: m_led = dat[3:0];
                2'd1: m_out = dat[7:0];
                2'd2: m_dir = dat[7:0];
                default: ;
            endcase
        end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        step();
        a2 = wb_ack_o; d2 = wb_dat_o;
        hs_ok = !a0 && a1 && !a2 && (d2 == 0);
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex; bit ok;
        reset_n = 0; step(); step();
        reset_n = 1; step(); step(); step();
        checks++; if (led_o !== LR) begin failures++; $display("FAIL reset_led got=%h exp=%h", led_o, LR); end
        checks++; if (io_oe !== 8'h00) begin failures++; $display("FAIL reset_io_oe got=%h exp=00", io_oe); end
        checks++; if (io_o !== 8'h00) begin failures++; $display("FAIL reset_io_o got=%h exp=00", io_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
        checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
        wb_access(4'hC, 0, 4'hF, 0, rd, ex, ok);
        checks++; if (rd !== 32'h100 || !ok) begin failures++; $display("FAIL reset_status got=%h hs=%0d exp=00000100", rd, ok); end
    endtask

    task automatic test_io();
        logic [31:0] rd, ex; bit ok;
        io_i = 8'h3C;
        wb_access(4'h8, 32'h0F, 4'h1, 1, rd, ex, ok);
        checks++; if (!ok) begin failures++; $display("FAIL io_dir_handshake got=%0d exp=1", ok); end
        wb_access(4'h4, 32'hA5, 4'h1, 1, rd, ex, ok);
        checks++; if (!ok) begin failures++; $display("FAIL io_out_handshake got=%0d exp=1", ok); end
        checks++; if (io_oe !== 8'h0F) begin failures++; $display("FAIL io_oe got=%h exp=0f", io_oe); end
        checks++; if (io_o !== 8'hA5) begin failures++; $display("FAIL io_o got=%h exp=a5", io_o); end
        wb_access(4'hC, 0, 4'hF, 0, rd, ex, ok);
        checks++; if (rd[7:0] !== 8'h3C || rd !== ex) begin failures++; $display("FAIL io_sync got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_led_sel();
        logic [31:0] rd, ex; bit ok;
        wb_access(4'h0, 32'hFF, 4'h2, 1, rd, ex, ok);
        checks++; if (led_o !== LR) begin failures++; $display("FAIL led_sel1 got=%h exp=%h", led_o, LR); end
        wb_access(4'h0, 32'hFF, 4'h1, 1, rd, ex, ok);
        checks++; if (led_o !== 4'hF) begin failures++; $display("FAIL led_sel0 got=%h exp=f", led_o); end
        wb_access(4'h0, 0, 4'hF, 0, rd, ex, ok);
        checks++; if (rd !== 32'h0000000F || !ok) begin failures++; $display("FAIL led_read got=%h exp=0000000f", rd); end
    endtask

    task automatic test_debounce();
        logic [31:0] rd, ex; bit ok;
        int first, p0, bad;
        first = -1; bad = 0; p0 = m_presses;
        key1_i = 0; repeat (5) step();
        key1_i = 1; step();
        key1_i = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (irq_o === 1'b1 && first < 0) first = i;
            if (irq_o !== m_evt) bad++;
        end
        checks++; if (first != 2 + D) begin failures++; $display("FAIL debounce_latency got=%0d exp=%0d", first, 2 + D); end
        checks++; if (bad != 0) begin failures++; $display("FAIL debounce_irq_track got=%0d exp=0", bad); end
        checks++; if (m_presses - p0 != 1) begin failures++; $display("FAIL debounce_once got=%0d exp=1", m_presses - p0); end
        wb_access(4'hC, 0, 4'hF, 0, rd, ex, ok);
        checks++; if (rd[9:8] !== 2'b10 || rd !== ex) begin failures++; $display("FAIL debounce_status got=%h exp=%h", rd, ex); end
        key1_i = 1; repeat (14) step();
        checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL release_no_clear got=%b exp=1", irq_o); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd, ex; bit ok;
        wb_access(4'hC, 32'h200, 4'h2, 1, rd, ex, ok);
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL w1c_clear got=%b exp=0", irq_o); end
        key1_i = 0; repeat (2 + D - 1) step();
        wb_access(4'hC, 32'h200, 4'h2, 1, rd, ex, ok);
        checks++; if (irq_o !== 1'b1 || m_evt !== 1'b1) begin failures++; $display("FAIL w1c_race got=%b exp=1", irq_o); end
        key1_i = 1; repeat (14) step();
        wb_access(4'hC, 32'h200, 4'h2, 1, rd, ex, ok);
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL w1c_later got=%b exp=0", irq_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ex; bit ok;
        wb_adr_i = 4'h0; wb_dat_i = 32'h9; wb_sel_i = 4'h1; wb_we_i = 1;
        wb_cyc_i = 1; wb_stb_i = 1; reset_n = 0;
        step();
        checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL midreset_ack got=%b exp=0", wb_ack_o); end
        checks++; if (led_o !== LR) begin failures++; $display("FAIL midreset_led got=%h exp=%h", led_o, LR); end
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; reset_n = 1;
        step();
        wb_access(4'h0, 32'h9, 4'h1, 1, rd, ex, ok);
        checks++; if (!ok || led_o !== 4'h9) begin failures++; $display("FAIL reissue got=%h hs=%0d exp=9", led_o, ok); end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, dat; bit ok;
        logic [3:0] adr, sel; logic we;
        int bad;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            io_i = 8'($urandom);
            adr  = {2'($urandom_range(0, 3)), 2'($urandom)};
            dat  = $urandom;
            sel  = 4'($urandom);
            we   = 1'($urandom);
            wb_access(adr, dat, sel, we, rd, ex, ok);
            if (!ok || (!we && rd !== ex) || led_o !== m_led || io_o !== m_out ||
                io_oe !== m_dir || irq_o !== m_evt) begin
                bad++;
                $display("FAIL random_%0d adr=%h we=%b rd=%h exp=%h led=%h/%h out=%h/%h dir=%h/%h",
                         n, adr, we, rd, ex, led_o, m_led, io_o, m_out, io_oe, m_dir);
            end
        end
        checks++; if (bad != 0) failures++;
    endtask

    initial begin
        reset_n = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; wb_we_i = 0;
        wb_stb_i = 0; wb_cyc_i = 0; io_i = 0; key1_i = 1;
        test_reset();
        test_io();
        test_led_sel();
        test_debounce();
        test_w1c_race();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
